// File: rtl/pipe_mips32_pkg.sv
// Shared opcodes, instruction classes and pipeline-register layouts for the
// five-stage MIPS32 subset core.
package pipe_mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} instr_class_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] npc;
  } ifid_t;

  typedef struct packed {
    instr_class_e cls;
    alu_op_e      op;
    logic         beqz;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   dest;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  imm;
    logic [31:0]  npc;
  } idex_t;

  typedef struct packed {
    instr_class_e cls;
    logic [4:0]   dest;
    logic [31:0]  alu;
    logic [31:0]  b;
  } exmem_t;

  typedef struct packed {
    instr_class_e cls;
    logic [4:0]   dest;
    logic [31:0]  data;
  } memwb_t;

  localparam ifid_t  IFID_BUBBLE  = '{valid: 1'b0, ir: 32'd0, npc: 32'd0};
  localparam idex_t  IDEX_BUBBLE  = '{cls: NOP, op: ALU_ADD, beqz: 1'b0, rs: 5'd0, rt: 5'd0,
                                      dest: 5'd0, a: 32'd0, b: 32'd0, imm: 32'd0, npc: 32'd0};
  localparam exmem_t EXMEM_BUBBLE = '{cls: NOP, dest: 5'd0, alu: 32'd0, b: 32'd0};
  localparam memwb_t MEMWB_BUBBLE = '{cls: NOP, dest: 5'd0, data: 32'd0};

  function automatic instr_class_e classify(input logic [5:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  function automatic alu_op_e alu_op_of(input logic [5:0] opc);
    case (opc)
      OP_SUB, OP_SUBI: return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_SLT, OP_SLTI: return ALU_SLT;
      OP_MUL:          return ALU_MUL;
      default:         return ALU_ADD;
    endcase
  endfunction

  function automatic logic writes_reg(input instr_class_e c);
    return (c == RR_ALU) || (c == RM_ALU) || (c == LOAD);
  endfunction

  function automatic logic uses_rs(input instr_class_e c);
    return (c == RR_ALU) || (c == RM_ALU) || (c == LOAD) || (c == STORE) || (c == BRANCH);
  endfunction

  function automatic logic uses_rt(input instr_class_e c);
    return (c == RR_ALU) || (c == STORE);
  endfunction

endpackage

// File: rtl/pipe_mips32_if.sv
// Operand/result bundle between the pipeline's EX stage and the ALU.
interface pipe_mips32_if;
  import pipe_mips32_pkg::*;

  alu_op_e     op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;

  modport master (output op, a, b, input y);
  modport slave  (input op, a, b, output y);
endinterface

// File: rtl/pipe_mips32_alu.sv
// Combinational 32-bit ALU: add/sub/and/or, signed set-less-than, low-word multiply.
module pipe_mips32_alu
  import pipe_mips32_pkg::*;
(
  pipe_mips32_if.slave bus
);

  always_comb begin
    bus.y = 32'd0;
    case (bus.op)
      ALU_ADD: bus.y = bus.a + bus.b;
      ALU_SUB: bus.y = bus.a - bus.b;
      ALU_AND: bus.y = bus.a & bus.b;
      ALU_OR:  bus.y = bus.a | bus.b;
      ALU_SLT: bus.y = {31'd0, $signed(bus.a) < $signed(bus.b)};
      ALU_MUL: bus.y = bus.a * bus.b;
      default: bus.y = 32'd0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32 subset with full forwarding, load-use stall,
// EX-stage branch resolution and a unified combinational-read memory.
module pipe_mips32
  import pipe_mips32_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic clk1,
  input  logic rst,
  output logic halted
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  logic        halt_fetch_q, halt_fetch_d;
  logic [31:0] pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic [5:0]   id_opc;
  logic [4:0]   id_rs, id_rt, id_rd, id_dest;
  instr_class_e id_cls;
  logic [31:0]  id_imm, id_a, id_b;
  logic         wb_we, ld_hazard, ex_taken;
  logic [31:0]  ex_a, ex_b;

  pipe_mips32_if alu_bus ();
  pipe_mips32_alu u_alu (.bus(alu_bus.slave));

  assign halted  = HALTED;
  assign id_opc  = ifid_q.ir[31:26];
  assign id_rs   = ifid_q.ir[25:21];
  assign id_rt   = ifid_q.ir[20:16];
  assign id_rd   = ifid_q.ir[15:11];
  assign id_imm  = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
  assign id_cls  = ifid_q.valid ? classify(id_opc) : NOP;
  assign id_dest = (id_cls == RR_ALU) ? id_rd :
                   ((id_cls == RM_ALU) || (id_cls == LOAD)) ? id_rt : 5'd0;

  // Write-through register read: a WB write this cycle is seen by ID directly.
  assign wb_we = writes_reg(memwb_q.cls) && (memwb_q.dest != 5'd0);
  assign id_a  = (id_rs == 5'd0) ? 32'd0 :
                 (wb_we && memwb_q.dest == id_rs) ? memwb_q.data : Reg[id_rs];
  assign id_b  = (id_rt == 5'd0) ? 32'd0 :
                 (wb_we && memwb_q.dest == id_rt) ? memwb_q.data : Reg[id_rt];

  // Loads never forward from EX/MEM; the stall below keeps a consumer out of EX until the load reaches WB.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v,
                                      input exmem_t em, input memwb_t mw);
    if (r == 5'd0)                                              return 32'd0;
    if (((em.cls == RR_ALU) || (em.cls == RM_ALU)) && em.dest == r) return em.alu;
    if (writes_reg(mw.cls) && mw.dest == r)                     return mw.data;
    return v;
  endfunction

  assign ex_a = fwd(idex_q.rs, idex_q.a, exmem_q, memwb_q);
  assign ex_b = fwd(idex_q.rt, idex_q.b, exmem_q, memwb_q);

  assign alu_bus.op = idex_q.op;
  assign alu_bus.a  = ex_a;
  assign alu_bus.b  = (idex_q.cls == RR_ALU) ? ex_b : idex_q.imm;

  assign ex_taken  = (idex_q.cls == BRANCH) && (idex_q.beqz ? (ex_a == 32'd0) : (ex_a != 32'd0));
  assign ld_hazard = (idex_q.cls == LOAD) && (idex_q.dest != 5'd0) &&
                     ((uses_rs(id_cls) && id_rs == idex_q.dest) ||
                      (uses_rt(id_cls) && id_rt == idex_q.dest));

  always_comb begin
    pc_d         = PC;
    ifid_d       = ifid_q;
    halt_fetch_d = halt_fetch_q;
    idex_d       = IDEX_BUBBLE;

    exmem_d.cls  = idex_q.cls;
    exmem_d.dest = idex_q.dest;
    exmem_d.alu  = alu_bus.y;
    exmem_d.b    = ex_b;

    memwb_d.cls  = exmem_q.cls;
    memwb_d.dest = exmem_q.dest;
    memwb_d.data = (exmem_q.cls == LOAD) ? Mem[exmem_q.alu[AW-1:0]] : exmem_q.alu;

    // A taken branch outranks a wrong-path HLT sitting in ID.
    if (ex_taken) begin
      pc_d   = idex_q.npc + idex_q.imm;
      ifid_d = IFID_BUBBLE;
    end else if (ld_hazard) begin
      pc_d   = PC;
    end else if (halt_fetch_q || id_cls == HALT) begin
      ifid_d       = IFID_BUBBLE;
      halt_fetch_d = 1'b1;
    end else begin
      ifid_d.valid = 1'b1;
      ifid_d.ir    = Mem[PC[AW-1:0]];
      ifid_d.npc   = PC + 32'd1;
      pc_d         = PC + 32'd1;
    end

    if (!ex_taken && !ld_hazard) begin
      idex_d.cls  = id_cls;
      idex_d.op   = alu_op_of(id_opc);
      idex_d.beqz = (id_opc == OP_BEQZ);
      idex_d.rs   = id_rs;
      idex_d.rt   = id_rt;
      idex_d.dest = id_dest;
      idex_d.a    = id_a;
      idex_d.b    = id_b;
      idex_d.imm  = id_imm;
      idex_d.npc  = ifid_q.npc;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      PC           <= RESET_PC;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      halt_fetch_q <= 1'b0;
      ifid_q       <= IFID_BUBBLE;
      idex_q       <= IDEX_BUBBLE;
      exmem_q      <= EXMEM_BUBBLE;
      memwb_q      <= MEMWB_BUBBLE;
    end else if (!HALTED) begin
      PC           <= pc_d;
      HALTED       <= (memwb_q.cls == HALT);
      TAKEN_BRANCH <= ex_taken;
      halt_fetch_q <= halt_fetch_d;
      ifid_q       <= ifid_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
    end
  end

  // Architectural storage is never reset so preloaded contents survive.
  always_ff @(posedge clk1) begin
    if (!HALTED) begin
      if (wb_we)                 Reg[memwb_q.dest]          <= memwb_q.data;
      if (exmem_q.cls == STORE)  Mem[exmem_q.alu[AW-1:0]]   <= exmem_q.b;
    end
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed program bench for pipe_mips32: expected architectural results are
// queued when a program is loaded and drained once the core halts.
module tb_pipe_mips32;
  import pipe_mips32_pkg::*;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic halted;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          sel;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] r2_q[$];
  logic [31:0] alu_q[$];

  pipe_mips32 #(.MEM_WORDS(1024), .RESET_PC(32'd0)) dut (
    .clk1   (clk1),
    .rst    (rst),
    .halted (halted)
  );

  pipe_mips32_if chk_if ();
  pipe_mips32_alu u_chk (.bus(chk_if.slave));

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_reg(input string tag, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = 0; e.idx = idx; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_mem(input string tag, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = 1; e.idx = idx; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drain_sb();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = (e.sel == 0) ? dut.Reg[e.idx] : dut.Mem[e.idx];
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic start(input string name, input logic [31:0] prog[$]);
    @(negedge clk1);
    rst = 1'b1;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
    @(negedge clk1);
    check({name, "_rst_pc"},     dut.PC, 32'd0);
    check({name, "_rst_halted"}, {31'd0, halted}, 32'd0);
    check({name, "_rst_taken"},  {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic run(input string name, input int budget, input bit track_r2,
                     output int cycles, output int br);
    logic [31:0] prev;
    logic [31:0] want;
    prev   = dut.Reg[2];
    cycles = 0;
    br     = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk1);
      cycles++;
      if (dut.TAKEN_BRANCH) br++;
      if (track_r2 && dut.Reg[2] !== prev) begin
        prev = dut.Reg[2];
        want = (r2_q.size() > 0) ? r2_q.pop_front() : 32'hdeadbeef;
        check({name, "_r2_step"}, prev, want);
      end
    end
    check({name, "_halted"}, {31'd0, halted}, 32'd1);
    $display("prog %s cycles=%0d taken_pulses=%0d", name, cycles, br);
  endtask

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } alu_vec_t;

  initial begin
    logic [31:0] p[$];
    logic [31:0] fact[$];
    alu_vec_t    vecs[$];
    alu_vec_t    v;
    int          cyc;
    int          br;

    chk_if.op = ALU_ADD;
    chk_if.a  = 32'd0;
    chk_if.b  = 32'd0;

    // Standalone ALU spot checks through the interface.
    vecs = '{'{ALU_MUL, 32'h00010000, 32'h00010000, 32'h00000000},
             '{ALU_MUL, 32'hffffffff, 32'h00000003, 32'hfffffffd},
             '{ALU_SLT, 32'hffffffff, 32'h00000001, 32'h00000001},
             '{ALU_SLT, 32'h00000001, 32'hffffffff, 32'h00000000},
             '{ALU_ADD, 32'h7fffffff, 32'h00000001, 32'h80000000},
             '{ALU_SUB, 32'h00000000, 32'h00000001, 32'hffffffff}};
    foreach (vecs[i]) begin
      v = vecs[i];
      chk_if.op = v.op;
      chk_if.a  = v.a;
      chk_if.b  = v.b;
      alu_q.push_back(v.y);
      #1;
      check("alu_vec", chk_if.y, alu_q.pop_front());
      $display("alu op=%0d a=%h b=%h y=%h", v.op, v.a, v.b, chk_if.y);
    end

    // Factorial of 7 with R2 step tracking.
    fact = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
             32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
             32'hfc000000};
    dut.Mem[200] = 32'd7;
    dut.Mem[198] = 32'd0;
    r2_q = '{32'd1, 32'd7, 32'd42, 32'd210, 32'd840, 32'd2520, 32'd5040};
    expect_mem("fact_mem198", 198, 32'd5040);
    expect_mem("fact_mem200", 200, 32'd7);
    expect_reg("fact_r3", 3, 32'd0);
    expect_reg("fact_r2", 2, 32'd5040);
    start("fact", fact);
    run("fact", 80, 1'b1, cyc, br);
    check("fact_r2_steps_left", r2_q.size(), 32'd0);
    check("fact_taken_count", br, 32'd6);
    drain_sb();
    repeat (5) @(negedge clk1);
    check("fact_frozen_pc", dut.PC, 32'd11);
    check("fact_frozen_mem198", dut.Mem[198], 32'd5040);

    // Reset mid-loop, then rerun.
    dut.Mem[198] = 32'd0;
    start("fact_rerun", fact);
    repeat (20) @(negedge clk1);
    rst = 1'b1;
    #1;
    check("midrst_pc", dut.PC, 32'd0);
    check("midrst_halted", {31'd0, dut.HALTED}, 32'd0);
    check("midrst_mem200", dut.Mem[200], 32'd7);
    check("midrst_mem198", dut.Mem[198], 32'd0);
    @(negedge clk1);
    rst = 1'b0;
    expect_mem("rerun_mem198", 198, 32'd5040);
    expect_reg("rerun_r2", 2, 32'd5040);
    expect_reg("rerun_r3", 3, 32'd0);
    run("fact_rerun", 80, 1'b0, cyc, br);
    drain_sb();

    // Back-to-back dependencies resolved by forwarding alone.
    p = '{32'h2801000a, 32'h28220014, 32'h00221800, 32'hfc000000};
    expect_reg("b2b_r1", 1, 32'd10);
    expect_reg("b2b_r2", 2, 32'd30);
    expect_reg("b2b_r3", 3, 32'd40);
    start("b2b", p);
    run("b2b", 40, 1'b0, cyc, br);
    check("b2b_cycles", cyc, 32'd8);
    drain_sb();

    // Load-use: one stall cycle, then forward.
    p = '{32'h20020032, 32'h28430001, 32'hfc000000};
    dut.Mem[50] = 32'd85;
    expect_reg("lu_r2", 2, 32'd85);
    expect_reg("lu_r3", 3, 32'd86);
    start("loaduse", p);
    run("loaduse", 40, 1'b0, cyc, br);
    check("lu_cycles", cyc, 32'd8);
    drain_sb();

    // Taken BEQZ flushes the two younger instructions.
    p = '{32'h38000002, 32'h28050009, 32'h24050064, 32'hfc000000};
    dut.Mem[100] = 32'h00001234;
    expect_reg("br_r5", 5, 32'd5);
    expect_mem("br_mem100", 100, 32'h00001234);
    start("branch", p);
    run("branch", 40, 1'b0, cyc, br);
    check("br_taken_pulses", br, 32'd1);
    drain_sb();

    // Writes to R0 are discarded and never forwarded.
    p = '{32'h28000005, 32'h00003800, 32'hfc000000};
    expect_reg("r0_stays_zero", 0, 32'd0);
    expect_reg("r0_fwd_r7", 7, 32'd0);
    start("r0", p);
    run("r0", 40, 1'b0, cyc, br);
    drain_sb();

    // Signed compare, subtract and logic mix.
    p = '{32'h2808ffff, 32'h31090001, 32'h04085000, 32'h090a5800, 32'hfc000000};
    expect_reg("mix_r8", 8, 32'hffffffff);
    expect_reg("mix_slti_r9", 9, 32'd1);
    expect_reg("mix_sub_r10", 10, 32'd1);
    expect_reg("mix_and_r11", 11, 32'd1);
    start("mix", p);
    run("mix", 40, 1'b0, cyc, br);
    drain_sb();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
